// File: rtl/uart_pkg.sv
// Constants and types shared by both ends of the 8N1 serial link.
// The default clock and baud constants are kept here so the transmitter and receiver agree.
package uart_pkg;

  localparam int unsigned CLK_FREQ      = 100_000_000;
  localparam int unsigned BAUD_RATE     = 9_600;
  localparam int unsigned NUM_DATA_BITS = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word fall-through read data and a reset flush.
// depth must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int unsigned depth = 4,
  parameter int unsigned width = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [width-1:0]         push_data,
  input  logic                     pop,
  output logic [width-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: bytes are queued through a small FIFO and sent as
// start bit, eight data bits LSB-first, stop bit, with back-to-back frames when queued.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq   = CLK_FREQ,
  parameter int unsigned baud_rate  = BAUD_RATE,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          TxD,
  output logic                          busy,
  output logic [$clog2(fifo_depth):0]   fifo_count
);

  localparam int unsigned BIT_CYCLES = clk_freq / baud_rate;
  localparam int unsigned BCW        = cnt_width(BIT_CYCLES);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BIT_CYCLES - 1);
  localparam int unsigned IW         = cnt_width(NUM_DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(NUM_DATA_BITS - 1);

  tx_state_t                state;
  logic [BCW-1:0]           baud_cnt;
  logic [IW-1:0]            bit_idx;
  logic [NUM_DATA_BITS-1:0] shift;
  logic                     txd_q;

  logic                     baud_wrap;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [NUM_DATA_BITS-1:0] head;

  uart_tx_fifo #(
    .depth (fifo_depth),
    .width (NUM_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign tx_ready  = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign TxD       = txd_q;

  // A byte leaves the FIFO either from IDLE or at the very end of a stop bit,
  // which is what makes queued frames run with no idle gap.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      pop = (state == IDLE) || ((state == STOP) && baud_wrap);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd_q    <= STOP_BIT;
    end else begin
      baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          txd_q    <= STOP_BIT;
          if (pop) begin
            shift <= head;
            state <= START;
            txd_q <= START_BIT;
          end
        end
        START: begin
          if (baud_wrap) begin
            state   <= DATA;
            bit_idx <= '0;
            txd_q   <= shift[0];
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              txd_q <= STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              txd_q   <= shift[1];
            end
          end
        end
        STOP: begin
          if (baud_wrap) begin
            if (pop) begin
              shift <= head;
              state <= START;
              txd_q <= START_BIT;
            end else begin
              state <= IDLE;
              txd_q <= STOP_BIT;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd_q <= STOP_BIT;
        end
      endcase
    end
  end

endmodule
